led_scan_controller: RTL and testbench
======================================

Name: led_scan_controller

Overview:
Drives column multiplexing for the N x N Conway LED array. It sits directly upstream of the LED array driver and supplies its enable, column index and cell-grid inputs.
- Steps through columns 0..N-1 with a programmable dwell time per column.
- Inserts a blanking interval at the start of each column slot to suppress ghosting.
- Double-buffers incoming cell frames from the game-of-life core, swapping only at frame boundaries so the display never tears.

Parameters:
N, 5, grid size; legal range 1..8.
COLUMN_TICKS, 1000, clk cycles per column slot, blanking included; must be >= 2.
BLANK_TICKS, 8, cycles at the start of each slot with ena low; legal range 1..COLUMN_TICKS-1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
cells_in  input  N*N  next frame from the life core; same bit ordering as cells_out.
cells_valid  input  1  producer has a frame on cells_in.
cells_ready  output  1  pending buffer empty; transfer occurs when cells_valid && cells_ready.
ena  output  1  column enable to the array driver.
x  output  $clog2(N)+1  current column index; range 0..N-1.
cells_out  output  N*N  frame currently displayed.
frame_start  output  1  one-cycle pulse in the first cycle of each column-0 slot.

Behaviour:
- Reset (rst high at an edge): tick_cnt=0, col=0, state=S_BLANK, pending_full=0, display buffer=0.
  - Outputs during and after reset: ena=0, x=0, cells_out=0, cells_ready=1.
  - frame_start is forced 0 while rst is high.
- tick_cnt counts 0..COLUMN_TICKS-1 and increments every cycle.
  - At COLUMN_TICKS-1 it wraps to 0, and col advances: col N-1 wraps to 0.
- FSM:
  - S_BLANK -> S_DRIVE at the edge where tick_cnt==BLANK_TICKS-1.
  - S_DRIVE -> S_BLANK at the edge where tick_cnt==COLUMN_TICKS-1.
- ena = (state==S_DRIVE). ena is high for exactly COLUMN_TICKS-BLANK_TICKS cycles per slot.
- x = col, zero-extended. x changes only on the S_DRIVE->S_BLANK edge, so it is never modified while ena is high.
- frame_start = (col==0 && tick_cnt==0 && !rst). It is therefore high in the first cycle after reset release, and then once every N*COLUMN_TICKS cycles.
- Frame handshake:
  - cells_ready = !pending_full.
  - On an edge with cells_valid && cells_ready: capture cells_in into pending and set pending_full=1.
  - While cells_ready is low, cells_valid is ignored. The producer holds its data; nothing is dropped or overwritten.
- Swap happens at the wrap edge (col==N-1 && tick_cnt==COLUMN_TICKS-1):
  - If pending_full, then display <= pending and pending_full <= 0.
  - The new cells_out is visible in the frame_start cycle, and cells_ready is 1 in that same cycle.
- Handshake on the wrap edge itself (pending previously empty):
  - The swap uses the pre-edge pending_full=0, so no swap occurs.
  - The captured data waits in pending and is displayed one full frame later. There is no bypass path.
- cells_out is constant for an entire frame. It never changes mid-scan.
- Reset mid-operation: everything returns to reset values at that edge, and any pending frame is discarded.
- Elaboration: $error if any parameter is out of its legal range.

Decomposition:
- Package led_scan_pkg holds:
  - scan_state_t enum {S_BLANK, S_DRIVE};
  - a localparam function for the x width, $clog2(N)+1, shared with the array driver.
- Sub-module led_frame_buffer holds the pending/display register pair, the valid/ready logic and the swap input.
- The top level keeps the counters and the FSM.

Test Plan:
All scenarios use N=5, COLUMN_TICKS=10, BLANK_TICKS=2. Cycle 0 is the first cycle after rst falls.
1. Reset -> during rst: ena=0, x=0, cells_out=0, cells_ready=1, frame_start=0. After release: frame_start=1 at cycle 0 only; ena rises at cycle 2; ena falls at cycle 10 with x=1.
2. Free-running scan for 100 cycles -> x steps 0,1,2,3,4 every 10 cycles. ena is high in cycles 2-9, 12-19, and so on. frame_start is high at cycles 0, 50, 100. x never changes while ena=1.
3. cells_in=25'h1555555, cells_valid=1 for cycle 7 only -> cells_ready=0 from cycle 8. cells_out stays 0 through cycle 49, becomes 25'h1555555 at cycle 50, and cells_ready=1 at cycle 50.
4. Back-pressure: first frame A (25'h0000001) accepted at cycle 3; frame B (25'h1FFFFFF) held valid from cycle 5 -> B is accepted at cycle 50. cells_out=A during cycles 50-99 and B from cycle 100. No frame is lost.
5. Frame A (25'h00AAAAA) handshaken exactly at cycle 49 -> cells_out stays 0 through cycle 99 and becomes A at cycle 100. cells_ready is 0 during cycles 50-99.
6. Frame pending, rst pulsed at cycle 36 (col 3, tick 6) -> next cycle has ena=0, x=0, cells_out=0, cells_ready=1. The pending frame is never displayed. The scan restarts with frame_start=1 in the cycle after rst falls.

Source files
------------

// File: rtl/led_scan_pkg.sv
// led_scan_pkg: shared scan state encoding and column-index width helper
package led_scan_pkg;
  typedef enum logic {S_BLANK = 1'b0, S_DRIVE = 1'b1} scan_state_t;
  function automatic int x_width(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/led_frame_buffer.sv
// led_frame_buffer: pending/display frame pair with valid/ready intake and frame-boundary swap
module led_frame_buffer #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cells_in,
  input  logic         cells_valid,
  output logic         cells_ready,
  input  logic         swap,
  output logic [W-1:0] cells_out
);
  logic [W-1:0] pending;
  logic [W-1:0] display;
  logic         pending_full;
  logic         take;
  assign cells_ready = !pending_full;
  assign cells_out   = display;
  assign take        = cells_valid && cells_ready;
  // A frame taken on the swap edge itself is not forwarded; it waits a full frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending      <= '0;
      display      <= '0;
      pending_full <= 1'b0;
    end else begin
      if (take) pending <= cells_in;
      if (swap && pending_full) display <= pending;
      pending_full <= take || (pending_full && !swap);
    end
  end
endmodule

// File: rtl/led_scan_controller.sv
// led_scan_controller: column scan with per-slot blanking and tear-free double-buffered frames
module led_scan_controller
  import led_scan_pkg::*;
#(
  parameter int N            = 5,
  parameter int COLUMN_TICKS = 1000,
  parameter int BLANK_TICKS  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*N-1:0]         cells_in,
  input  logic                   cells_valid,
  output logic                   cells_ready,
  output logic                   ena,
  output logic [x_width(N)-1:0]  x,
  output logic [N*N-1:0]         cells_out,
  output logic                   frame_start
);
  localparam int XW = x_width(N);
  localparam int TW = $clog2(COLUMN_TICKS);
  localparam logic [TW-1:0] TICK_LAST  = TW'(COLUMN_TICKS - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
  localparam logic [XW-1:0] COL_LAST   = XW'(N - 1);
  if (N < 1 || N > 8) begin : g_bad_n
    $error("led_scan_controller: N=%0d outside 1..8", N);
  end
  if (COLUMN_TICKS < 2) begin : g_bad_ct
    $error("led_scan_controller: COLUMN_TICKS=%0d must be >= 2", COLUMN_TICKS);
  end
  if (BLANK_TICKS < 1 || BLANK_TICKS > COLUMN_TICKS - 1) begin : g_bad_bt
    $error("led_scan_controller: BLANK_TICKS=%0d outside 1..COLUMN_TICKS-1", BLANK_TICKS);
  end
  logic [TW-1:0] tick_cnt;
  logic [XW-1:0] col;
  scan_state_t   state;
  logic          tick_last;
  logic          wrap;
  assign tick_last = tick_cnt == TICK_LAST;
  assign wrap      = tick_last && col == COL_LAST;
  // col only moves together with DRIVE->BLANK, so x is stable whenever ena is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      col      <= '0;
      state    <= S_BLANK;
    end else begin
      tick_cnt <= tick_last ? '0 : tick_cnt + 1'b1;
      col      <= wrap ? '0 : tick_last ? col + 1'b1 : col;
      state    <= (state == S_BLANK && tick_cnt == BLANK_LAST) ? S_DRIVE :
                  (state == S_DRIVE && tick_last) ? S_BLANK : state;
    end
  end
  assign ena         = state == S_DRIVE;
  assign x           = col;
  assign frame_start = col == '0 && tick_cnt == '0 && !rst;
  led_frame_buffer #(.W(N*N)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .cells_in    (cells_in),
    .cells_valid (cells_valid),
    .cells_ready (cells_ready),
    .swap        (wrap),
    .cells_out   (cells_out)
  );
endmodule

// File: tb/tb_led_scan_controller.sv
// tb_led_scan_controller: table vectors, directed corner sequences and random traffic vs a cycle-count model
module tb_led_scan_controller;
  localparam int N  = 5;
  localparam int CT = 10;
  localparam int BT = 2;
  localparam int W  = N * N;
  localparam int FRAME = N * CT;
  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] cells_in;
  logic         cells_valid;
  logic         cells_ready;
  logic         ena;
  logic [3:0]   x;
  logic [W-1:0] cells_out;
  logic         frame_start;
  led_scan_controller #(.N(N), .COLUMN_TICKS(CT), .BLANK_TICKS(BT)) dut (
    .clk         (clk),
    .rst         (rst),
    .cells_in    (cells_in),
    .cells_valid (cells_valid),
    .cells_ready (cells_ready),
    .ena         (ena),
    .x           (x),
    .cells_out   (cells_out),
    .frame_start (frame_start)
  );
  always #5 clk = ~clk;
  typedef struct {
    int           c;
    logic         v;
    logic [W-1:0] d;
    logic         ena;
    logic [3:0]   x;
    logic         fs;
    logic         rdy;
    logic [W-1:0] out;
  } vec_t;
  vec_t tbl[12];
  int pass_cnt = 0;
  int chk_cnt  = 0;
  // Reference: cycle index since reset release plus a queue of accepted frames.
  int           cyc  = 0;
  bit           live = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] disp = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask
  task automatic drive(input logic r, input logic v, input logic [W-1:0] d);
    #1;
    rst = r;
    cells_valid = v;
    cells_in = d;
  endtask
  task automatic sample;
    @(negedge clk);
    if (live) begin
      chk("ena", 32'(ena), 32'((cyc % CT) >= BT));
      chk("x", 32'(x), 32'((cyc / CT) % N));
      chk("frame_start", 32'(frame_start), 32'((cyc % FRAME) == 0 && !rst));
      chk("cells_ready", 32'(cells_ready), 32'(q.size() == 0));
      chk("cells_out", 32'(cells_out), 32'(disp));
    end
  endtask
  task automatic commit;
    @(posedge clk);
    live = 1;
    if (rst) begin
      cyc = 0;
      q.delete();
      disp = '0;
    end else begin
      if (cells_valid && q.size() == 0) q.push_back(cells_in);
      else if (cyc % FRAME == FRAME - 1 && q.size() != 0) disp = q.pop_front();
      cyc++;
    end
  endtask
  task automatic step(input logic r, input logic v, input logic [W-1:0] d);
    drive(r, v, d);
    sample;
    commit;
  endtask
  task automatic do_reset;
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
  endtask
  initial begin
    int k;
    int acc;
    logic v;
    logic hold;
    logic [W-1:0] d;
    tbl[0]  = '{0,   0, '0,          0, 0, 1, 1, '0};
    tbl[1]  = '{1,   0, '0,          0, 0, 0, 1, '0};
    tbl[2]  = '{2,   0, '0,          1, 0, 0, 1, '0};
    tbl[3]  = '{7,   1, 25'h1555555, 1, 0, 0, 1, '0};
    tbl[4]  = '{8,   0, '0,          1, 0, 0, 0, '0};
    tbl[5]  = '{9,   0, '0,          1, 0, 0, 0, '0};
    tbl[6]  = '{10,  0, '0,          0, 1, 0, 0, '0};
    tbl[7]  = '{12,  0, '0,          1, 1, 0, 0, '0};
    tbl[8]  = '{49,  0, '0,          1, 4, 0, 0, '0};
    tbl[9]  = '{50,  0, '0,          0, 0, 1, 1, 25'h1555555};
    tbl[10] = '{51,  0, '0,          0, 0, 0, 1, 25'h1555555};
    tbl[11] = '{100, 0, '0,          0, 0, 1, 1, 25'h1555555};
    rst = 1'b1;
    cells_valid = 1'b0;
    cells_in = '0;
    commit;
    do_reset;
    for (int c = 0; c <= 101; c++) begin
      k = -1;
      foreach (tbl[i]) if (tbl[i].c == c) k = i;
      v = 1'b0;
      d = '0;
      if (k >= 0) begin
        v = tbl[k].v;
        d = tbl[k].d;
      end
      drive(1'b0, v, d);
      sample;
      if (k >= 0) begin
        chk("tbl_ena", 32'(ena), 32'(tbl[k].ena));
        chk("tbl_x", 32'(x), 32'(tbl[k].x));
        chk("tbl_frame_start", 32'(frame_start), 32'(tbl[k].fs));
        chk("tbl_cells_ready", 32'(cells_ready), 32'(tbl[k].rdy));
        chk("tbl_cells_out", 32'(cells_out), 32'(tbl[k].out));
      end
      commit;
    end
    // Back-pressure: B held from cycle 5 until the buffer frees up.
    do_reset;
    hold = 1'b1;
    acc = -1;
    for (int c = 0; c < 110; c++) begin
      v = (cyc == 3) || (cyc >= 5 && hold);
      d = (cyc == 3) ? 25'h0000001 : 25'h1FFFFFF;
      drive(1'b0, v, d);
      sample;
      if (cyc >= 5 && v && q.size() == 0) acc = cyc;
      if (cyc == 75 || cyc == 99) chk("bp_out_a", 32'(cells_out), 32'(25'h0000001));
      if (cyc == 100) chk("bp_out_b", 32'(cells_out), 32'(25'h1FFFFFF));
      commit;
      if (acc >= 0) hold = 1'b0;
    end
    chk("bp_accept_cycle", 32'(acc), 32'd50);
    // Handshake on the wrap edge waits a whole extra frame.
    do_reset;
    for (int c = 0; c < 110; c++) begin
      drive(1'b0, cyc == 49, 25'h00AAAAA);
      sample;
      if (cyc == 99) chk("wrap_hs_out_99", 32'(cells_out), 32'd0);
      if (cyc == 60) chk("wrap_hs_ready_60", 32'(cells_ready), 32'd0);
      if (cyc == 100) chk("wrap_hs_out_100", 32'(cells_out), 32'(25'h00AAAAA));
      commit;
    end
    // Mid-scan reset discards the pending frame.
    do_reset;
    for (int c = 0; c < 36; c++) step(1'b0, c == 3, 25'h1234567);
    step(1'b1, 1'b0, '0);
    for (int c = 0; c < 110; c++) begin
      drive(1'b0, 1'b0, '0);
      sample;
      if (cyc == 0) begin
        chk("mid_rst_out", 32'(cells_out), 32'd0);
        chk("mid_rst_ready", 32'(cells_ready), 32'd1);
        chk("mid_rst_frame_start", 32'(frame_start), 32'd1);
      end
      if (cyc == 50 || cyc == 100) chk("mid_rst_discard", 32'(cells_out), 32'd0);
      commit;
    end
    for (int c = 0; c < 1500; c++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, W'($urandom));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
